// File: rtl/pdp1_pkg.sv
// Shared definitions for the PDP-1 operate-group (OPR) unit:
// mask bit indices, sequencer state encoding and the latched command bundle.
package pdp1_pkg;

    // OPR mask bit indices, MSB-first numbering [0:11]
    localparam int CLI     = 0;
    localparam int LAT     = 1;
    localparam int CMA     = 2;
    localparam int HLT     = 3;
    localparam int CLA     = 4;
    localparam int LAP     = 5;
    localparam int SWP_IA  = 6;
    localparam int SWP_AI  = 7;
    localparam int FSET    = 8;
    localparam int FNUM_HI = 9;
    localparam int FNUM_LO = 11;

    // Flag code that addresses every program flag at once
    localparam logic [2:0] FLAG_ALL = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_P1,
        ST_P2,
        ST_P3
    } opr_state_t;

    typedef struct packed {
        logic        op_i;
        logic [0:11] mask;
    } opr_cmd_t;

    // Flag number field, mask[9] is the code MSB
    function automatic logic [2:0] flag_code(input logic [0:11] m);
        return m[FNUM_HI:FNUM_LO];
    endfunction

endpackage

// File: rtl/pdp1_flag_reg.sv
// Program-flag register: decodes the 3-bit flag code, applies set/clear
// on op_en, and ORs in external device strobes (which beat a clear).
// Ports: clk, rst_n, op_en, op_set, code, ext_set[NFLAGS], flags[NFLAGS].
module pdp1_flag_reg
    import pdp1_pkg::*;
#(
    parameter int NFLAGS = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_en,
    input  logic              op_set,
    input  logic [2:0]        code,
    input  logic [NFLAGS-1:0] ext_set,
    output logic [NFLAGS-1:0] flags
);

    logic [NFLAGS-1:0] sel;
    logic [NFLAGS-1:0] flags_d;

    // Code n selects flag n; codes past NFLAGS select nothing
    always_comb begin
        sel = '0;
        if (code == FLAG_ALL) begin
            sel = '1;
        end else begin
            for (int i = 0; i < NFLAGS; i++) begin
                if (code == 3'(i + 1)) sel[i] = 1'b1;
            end
        end
    end

    // External set is applied last so it overrides a same-cycle clear
    always_comb begin
        flags_d = flags;
        if (op_en) begin
            if (op_set) flags_d = flags | sel;
            else        flags_d = flags & ~sel;
        end
        flags_d = flags_d | ext_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flags <= '0;
        else        flags <= flags_d;
    end

endmodule

// File: rtl/pdp1_opr_unit.sv
// PDP-1 operate-group unit: runs one OPR in three timed phases
// (P1 clear, P2 merge, P3 complement/swap/flag) and writes back AC/IO.
// Ports: clk, rst_n, start/busy/done handshake, op_i, op_mask[0:11],
// ac_i, io_i, tw_i, flag_set; results ac_o, io_o, ac_we, io_we, halt, flags_o.
module pdp1_opr_unit
    import pdp1_pkg::*;
#(
    parameter string PDP_MODEL = "PDP-1",
    parameter int    WORD      = 18,
    parameter int    NFLAGS    = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              op_i,
    input  logic [0:11]       op_mask,
    input  logic [WORD-1:0]   ac_i,
    input  logic [WORD-1:0]   io_i,
    input  logic [WORD-1:0]   tw_i,
    input  logic [NFLAGS-1:0] flag_set,
    output logic              busy,
    output logic              done,
    output logic [WORD-1:0]   ac_o,
    output logic [WORD-1:0]   io_o,
    output logic              ac_we,
    output logic              io_we,
    output logic              halt,
    output logic [NFLAGS-1:0] flags_o
);

    localparam bit IS_1D = (PDP_MODEL == "PDP-1D");

    opr_state_t      state_q;
    opr_state_t      state_d;
    opr_cmd_t        cmd_q;
    logic [WORD-1:0] ac_r;
    logic [WORD-1:0] io_r;
    logic [WORD-1:0] ac_fin;
    logic [WORD-1:0] io_fin;
    logic [WORD-1:0] flags_w;
    logic            ac_we_d;
    logic            io_we_d;
    logic [2:0]      fcode;
    logic            flag_en;

    // ---------------- sequencer ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_P1;
            ST_P1:   state_d = ST_P2;
            ST_P2:   state_d = ST_P3;
            ST_P3:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);

    // ---------------- P3 result logic ----------------
    assign flags_w = {{(WORD-NFLAGS){1'b0}}, flags_o};

    // Swaps read the P2 values, so setting both exchanges AC and IO;
    // the complements then act on the post-swap values.
    always_comb begin
        ac_fin = ac_r;
        io_fin = io_r;
        if (IS_1D) begin
            if (cmd_q.mask[SWP_IA]) ac_fin = io_r;
            if (cmd_q.mask[SWP_AI]) io_fin = ac_r;
            if (cmd_q.op_i)         io_fin = ~io_fin;
        end
        if (cmd_q.mask[CMA]) ac_fin = ~ac_fin;
    end

    always_comb begin
        ac_we_d = cmd_q.mask[LAT] | cmd_q.mask[CMA]
                | cmd_q.mask[CLA] | cmd_q.mask[LAP];
        io_we_d = cmd_q.mask[CLI];
        if (IS_1D) begin
            ac_we_d = ac_we_d | cmd_q.mask[SWP_IA];
            io_we_d = io_we_d | cmd_q.mask[SWP_AI] | cmd_q.op_i;
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q <= '0;
            ac_r  <= '0;
            io_r  <= '0;
            ac_o  <= '0;
            io_o  <= '0;
            done  <= 1'b0;
            ac_we <= 1'b0;
            io_we <= 1'b0;
            halt  <= 1'b0;
        end else begin
            done  <= 1'b0;
            ac_we <= 1'b0;
            io_we <= 1'b0;
            halt  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cmd_q.op_i <= op_i;
                        cmd_q.mask <= op_mask;
                        ac_r       <= ac_i;
                        io_r       <= io_i;
                    end
                end
                ST_P1: begin
                    if (cmd_q.mask[CLA]) ac_r <= '0;
                    if (cmd_q.mask[CLI]) io_r <= '0;
                end
                ST_P2: begin
                    ac_r <= ac_r
                          | (cmd_q.mask[LAT] ? tw_i    : '0)
                          | (cmd_q.mask[LAP] ? flags_w : '0);
                end
                ST_P3: begin
                    ac_o  <= ac_fin;
                    io_o  <= io_fin;
                    done  <= 1'b1;
                    ac_we <= ac_we_d;
                    io_we <= io_we_d;
                    halt  <= cmd_q.mask[HLT];
                end
                default: ;
            endcase
        end
    end

    // ---------------- program flags ----------------
    assign fcode   = flag_code(cmd_q.mask);
    assign flag_en = (state_q == ST_P3) && (fcode != 3'd0);

    pdp1_flag_reg #(
        .NFLAGS(NFLAGS)
    ) u_flags (
        .clk    (clk),
        .rst_n  (rst_n),
        .op_en  (flag_en),
        .op_set (cmd_q.mask[FSET]),
        .code   (fcode),
        .ext_set(flag_set),
        .flags  (flags_o)
    );

endmodule

// File: tb/tb_pdp1_opr_unit.sv
// Scoreboard bench for pdp1_opr_unit: one PDP-1 and one PDP-1D instance,
// directed OPR vectors with hand-computed results.
module tb_pdp1_opr_unit;
    import pdp1_pkg::*;

    localparam int W  = 18;
    localparam int NF = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start1, startd, op_i;
    logic [0:11]   op_mask;
    logic [W-1:0]  ac_i, io_i, tw_i;
    logic [NF-1:0] fs1, fsd;

    logic          busy1, done1, acwe1, iowe1, halt1;
    logic [W-1:0]  aco1, ioo1;
    logic [NF-1:0] fl1;
    logic          busyd, doned, acwed, ioweD, haltd;
    logic [W-1:0]  acod, iood;
    logic [NF-1:0] fld;

    pdp1_opr_unit #(.PDP_MODEL("PDP-1"), .WORD(W), .NFLAGS(NF)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op_i(op_i),
        .op_mask(op_mask), .ac_i(ac_i), .io_i(io_i), .tw_i(tw_i),
        .flag_set(fs1), .busy(busy1), .done(done1), .ac_o(aco1),
        .io_o(ioo1), .ac_we(acwe1), .io_we(iowe1), .halt(halt1),
        .flags_o(fl1)
    );

    pdp1_opr_unit #(.PDP_MODEL("PDP-1D"), .WORD(W), .NFLAGS(NF)) u1d (
        .clk(clk), .rst_n(rst_n), .start(startd), .op_i(op_i),
        .op_mask(op_mask), .ac_i(ac_i), .io_i(io_i), .tw_i(tw_i),
        .flag_set(fsd), .busy(busyd), .done(doned), .ac_o(acod),
        .io_o(iood), .ac_we(acwed), .io_we(ioweD), .halt(haltd),
        .flags_o(fld)
    );

    typedef struct {
        logic [W-1:0]  ac;
        logic [W-1:0]  io;
        logic          aw;
        logic          iw;
        logic          h;
        logic [NF-1:0] f;
    } exp_t;

    exp_t q1[$];
    exp_t qd[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %o expected %o", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] ac, input logic [W-1:0] io,
                                input logic aw, input logic iw, input logic h,
                                input logic [NF-1:0] f);
        exp_t e;
        e.ac = ac; e.io = io; e.aw = aw; e.iw = iw; e.h = h; e.f = f;
        return e;
    endfunction

    function automatic logic [0:11] mb(input int b);
        logic [0:11] r;
        r = '0;
        r[b] = 1'b1;
        return r;
    endfunction

    function automatic logic [0:11] fc(input int c);
        logic [0:11] r;
        r = '0;
        r[9:11] = c[2:0];
        return r;
    endfunction

    task automatic cmp_out(input string t, input exp_t e,
                           input logic [W-1:0] ac, input logic [W-1:0] io,
                           input logic aw, input logic iw, input logic h,
                           input logic [NF-1:0] f);
        chk({t, " ac_o"}, 32'(ac), 32'(e.ac));
        chk({t, " io_o"}, 32'(io), 32'(e.io));
        chk({t, " ac_we"}, 32'(aw), 32'(e.aw));
        chk({t, " io_we"}, 32'(iw), 32'(e.iw));
        chk({t, " halt"}, 32'(h), 32'(e.h));
        chk({t, " flags"}, 32'(f), 32'(e.f));
    endtask

    // Monitor: every done pops one expected result
    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL u1 unexpected done: got done=1 expected none");
            end else begin
                cmp_out("u1", q1.pop_front(), aco1, ioo1, acwe1, iowe1,
                        halt1, fl1);
            end
        end
        if (doned === 1'b1) begin
            if (qd.size() == 0) begin
                checks++; errors++;
                $display("FAIL u1d unexpected done: got done=1 expected none");
            end else begin
                cmp_out("u1d", qd.pop_front(), acod, iood, acwed, ioweD,
                        haltd, fld);
            end
        end
    end

    // Issue one OPR; also checks busy and the fixed 3-cycle done latency
    task automatic op(input bit dd, input logic oi, input logic [0:11] m,
                      input logic [W-1:0] a, input logic [W-1:0] io,
                      input logic [NF-1:0] fs, input bit poke,
                      input exp_t e);
        @(negedge clk);
        op_i = oi; op_mask = m; ac_i = a; io_i = io;
        if (dd) begin startd = 1'b1; qd.push_back(e); end
        else    begin start1 = 1'b1; q1.push_back(e); end
        @(negedge clk);
        start1 = 1'b0; startd = 1'b0;
        chk("busy in P1", 32'(dd ? busyd : busy1), 32'd1);
        @(negedge clk);
        if (poke) begin
            if (dd) startd = 1'b1; else start1 = 1'b1;
        end
        chk("done early P2", 32'(dd ? doned : done1), 32'd0);
        @(negedge clk);
        start1 = 1'b0; startd = 1'b0;
        fs1 = fs;
        chk("done early P3", 32'(dd ? doned : done1), 32'd0);
        @(negedge clk);
        fs1 = '0;
        chk("done latency", 32'(dd ? doned : done1), 32'd1);
        chk("busy at done", 32'(dd ? busyd : busy1), 32'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        start1 = 0; startd = 0; op_i = 0; op_mask = '0;
        ac_i = '0; io_i = '0; tw_i = 18'o000777; fs1 = '0; fsd = '0;
        repeat (2) @(negedge clk);
        chk("rst busy", 32'(busy1), 0);
        chk("rst done", 32'(done1), 0);
        chk("rst ac_o", 32'(aco1), 0);
        chk("rst io_o", 32'(ioo1), 0);
        chk("rst flags", 32'(fl1), 0);
        chk("rst d flags", 32'(fld), 0);
        rst_n = 1'b1;

        op(0, 0, mb(CLA) | mb(LAT) | mb(CMA), 18'o123456, 18'o0, '0, 0,
           mk(18'o777000, 18'o0, 1, 0, 0, 6'o00));
        op(0, 0, mb(FSET) | fc(3), 18'o5, 18'o7, '0, 0,
           mk(18'o5, 18'o7, 0, 0, 0, 6'b000100));
        op(0, 0, fc(7), 18'o5, 18'o7, '0, 0,
           mk(18'o5, 18'o7, 0, 0, 0, 6'b000000));
        op(0, 0, mb(FSET) | fc(7), 18'o5, 18'o7, '0, 0,
           mk(18'o5, 18'o7, 0, 0, 0, 6'b111111));
        op(0, 0, mb(CLA) | mb(LAP), 18'o5, 18'o7, '0, 0,
           mk(18'o77, 18'o7, 1, 0, 0, 6'b111111));
        op(0, 0, mb(HLT), 18'o11, 18'o22, '0, 0,
           mk(18'o11, 18'o22, 0, 0, 1, 6'b111111));
        op(0, 1, mb(SWP_IA) | mb(SWP_AI), 18'o11, 18'o22, '0, 0,
           mk(18'o11, 18'o22, 0, 0, 0, 6'b111111));
        op(0, 0, fc(2), 18'o1, 18'o2, 6'b000010, 0,
           mk(18'o1, 18'o2, 0, 0, 0, 6'b111111));
        op(0, 0, fc(2), 18'o1, 18'o2, '0, 0,
           mk(18'o1, 18'o2, 0, 0, 0, 6'b111101));
        op(0, 0, mb(CLI), 18'o3, 18'o55, '0, 1,
           mk(18'o3, 18'o0, 0, 1, 0, 6'b111101));
        repeat (4) @(negedge clk);

        op(1, 0, mb(SWP_IA) | mb(SWP_AI), 18'o1, 18'o2, '0, 0,
           mk(18'o2, 18'o1, 1, 1, 0, 6'o00));
        op(1, 1, mb(SWP_IA) | mb(SWP_AI), 18'o1, 18'o2, '0, 0,
           mk(18'o2, 18'o777776, 1, 1, 0, 6'o00));

        // Abort an OPR in P2 with reset
        @(negedge clk);
        op_i = 0; op_mask = mb(CLA) | mb(HLT); ac_i = 18'o4; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy1), 0);
        chk("abort done", 32'(done1), 0);
        chk("abort ac_o", 32'(aco1), 0);
        chk("abort io_o", 32'(ioo1), 0);
        chk("abort ac_we", 32'(acwe1), 0);
        chk("abort io_we", 32'(iowe1), 0);
        chk("abort halt", 32'(halt1), 0);
        chk("abort flags", 32'(fl1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done1 === 1'b1 || halt1 === 1'b1) seen = 1;
        end
        chk("abort no done", 32'(seen), 0);
        chk("u1 queue empty", 32'(q1.size()), 0);
        chk("u1d queue empty", 32'(qd.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pdp1_opr_unit.md
Name: pdp1_opr_unit

Overview:
Clocked, parametrised operate-group (OPR) execution unit for the PDP-1 core. It owns the program-flag register and performs the OPR micro-operations in three timed phases (clear, merge, complement/swap/flag), as the real machine does. An optional PDP-1D mode adds AC/IO swap and IO complement. The main sequencer hands it one OPR per start/done handshake and writes back AC/IO on the done cycle.

Parameters:
PDP_MODEL, "PDP-1", "PDP-1" or "PDP-1D"; "PDP-1D" enables mask bits 6/7 and the op_i IO complement.
WORD, 18, AC/IO/test-word width.
NFLAGS, 6, number of program flags, 1..6; flag codes above NFLAGS are ignored except code 7.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin OPR; sampled only in IDLE
op_i  in  1  indirect bit of the OPR word
op_mask  in  12  OPR mask [0:11], MSB-first
ac_i  in  WORD  AC value at start
io_i  in  WORD  IO value at start
tw_i  in  WORD  test-word switches
flag_set  in  NFLAGS  external flag-set strobes (I/O devices)
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse; results valid
ac_o  out  WORD  AC result
io_o  out  WORD  IO result
ac_we  out  1  AC write enable, with done
io_we  out  1  IO write enable, with done
halt  out  1  one-cycle pulse with done when mask[3] set
flags_o  out  NFLAGS  program flags; flag n at LSB-relative position n-1

Behaviour:
- Reset (async, rst_n low): state IDLE; busy, done, ac_we, io_we, halt = 0; ac_o, io_o = 0; flags = 0. Reset mid-operation aborts with no writeback and no halt.
- States: IDLE -> P1 -> P2 -> P3 -> IDLE. start in IDLE latches op_i, op_mask, ac_i, io_i into internal registers and moves to P1. start outside IDLE is ignored.
- Latency: start on cycle N; done, ac_we, io_we, halt asserted on cycle N+3 (the P3->IDLE edge). A new start is accepted on cycle N+3.
- P1 (clear): mask[4] clears AC; mask[0] clears IO.
- P2 (merge): mask[1] ORs tw_i (sampled in P2) into AC; mask[5] ORs flags, zero-extended to WORD, into AC.
- P3 (final): mask[2] complements AC. In PDP-1D only: op_i complements IO. mask[6] AC<=IO and mask[7] IO<=AC, both from P2 values, so both set is a swap. Flag op: when mask[9:11] != 0, mask[8]=1 sets the selected flag and mask[8]=0 clears it; code 7 selects all flags; codes 1..6 select flag n. Codes above NFLAGS select nothing.
- In "PDP-1", mask[6], mask[7] and op_i have no effect.
- ac_we is set when any of mask[1,2,4,5] or, in 1D, mask[6] is set. io_we is set when mask[0] is set or, in 1D, mask[7] or op_i is set. ac_o and io_o always present the computed values and hold until the next done.
- flag_set: ORed into the flags every cycle. If an external set and a P3 clear hit the same flag in the same cycle, the external set wins.
- flags_o is the registered flag state. The P2 merge uses the flags as they stand at the start of P2.
- Width: all AC/IO operations are bitwise on WORD bits with no carry.

Decomposition:
- Shared package pdp1_pkg holds: OPR mask bit index constants (CLI=0, LAT=1, CMA=2, HLT=3, CLA=4, LAP=5, SWP_IA=6, SWP_AI=7, FSET=8, FNUM=9..11), state encoding, and FLAG_ALL=3'd7.
- One sub-module, pdp1_flag_reg: holds the NFLAGS register and does code decode, set/clear and external-set priority.

Test Plan:
- PDP-1; ac_i=0o123456, mask CLA|LAT|CMA, tw_i=0o000777 -> done at start+3 with ac_o=0o777000, ac_we=1, io_we=0, halt=0.
- Flags reset to 0; mask FSET with code 3 -> flags_o=6'b000100; then code 7 with FSET=0 -> 6'b000000; then code 7 with FSET=1 followed by CLA|LAP -> ac_o=0o000077.
- PDP-1D; ac_i=0o1, io_i=0o2, mask bits 6 and 7 -> ac_o=0o2 and io_o=0o1. Same again with op_i=1 -> io_o=0o777776.
- flag_set[1] pulsed in the same cycle as a P3 clear of flag 2 -> flags_o bit1=1. start pulsed while busy -> ignored, and exactly one done.
- mask HLT only -> halt pulse with done, ac_we=io_we=0. rst_n dropped in P2 -> all outputs 0 immediately, no done. PDP-1 with mask[6] set -> ac_o unchanged.
